// File: rtl/window_mac_if.sv
// Handshake and data bundle between a window_mac and the block that drives it.
// The master side sources pairs and start; the slave side is the MAC itself.
interface window_mac_if #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40
);
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] pixel;
   logic [DATA_W-1:0] weight;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  result;
   logic              busy;

   modport master (
      output start, in_valid, pixel, weight, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  start, in_valid, pixel, weight, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/window_mac.sv
// Windowed multiply-accumulate: TAPS signed pixel*weight products summed into
// an ACC_W accumulator, each product built by a bit-serial shift-add multiplier.
module window_mac #(
   parameter int DATA_W = 16,
   parameter int TAPS   = 25,
   parameter int ACC_W  = 40
) (
   input logic         CLK,
   input logic         R,
   window_mac_if.slave bus
);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WAIT_TAP = 3'd1;
   localparam logic [2:0] MUL      = 3'd2;
   localparam logic [2:0] ACC      = 3'd3;
   localparam logic [2:0] DONE     = 3'd4;

   localparam int               CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_W - 1);
   localparam logic [7:0]       TAP_COUNT = 8'(TAPS);

   logic [2:0]          state_reg, state_next;
   logic [ACC_W-1:0]    acc_reg;
   logic [ACC_W-1:0]    result_reg;
   logic [7:0]          tap_cnt_reg;
   logic [CNT_W-1:0]    bit_cnt_reg;
   logic [2*DATA_W-1:0] mcand_reg;
   logic [2*DATA_W-1:0] prod_reg;
   logic [DATA_W-1:0]   mplier_reg;
   logic                sign_reg;

   logic [DATA_W-1:0]   pixel_mag, weight_mag;
   logic [ACC_W-1:0]    prod_ext, prod_signed, acc_sum;
   logic [7:0]          tap_cnt_inc;

   // Negating the most negative operand in DATA_W bits yields 2^(DATA_W-1)
   // when read unsigned, which is exactly the magnitude we want.
   assign pixel_mag  = bus.pixel[DATA_W-1]  ? ((~bus.pixel)  + DATA_W'(1)) : bus.pixel;
   assign weight_mag = bus.weight[DATA_W-1] ? ((~bus.weight) + DATA_W'(1)) : bus.weight;

   assign prod_ext    = {{(ACC_W-2*DATA_W){1'b0}}, prod_reg};
   assign prod_signed = sign_reg ? ((~prod_ext) + ACC_W'(1)) : prod_ext;
   assign acc_sum     = acc_reg + prod_signed;
   assign tap_cnt_inc = tap_cnt_reg + 8'd1;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:     if (bus.start) state_next = WAIT_TAP;
         WAIT_TAP: if (bus.in_valid) state_next = MUL;
         MUL:      if (bit_cnt_reg == BIT_LAST) state_next = ACC;
         ACC:      state_next = (tap_cnt_inc == TAP_COUNT) ? DONE : WAIT_TAP;
         DONE:     if (bus.out_ready) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge R) begin
      if (R) begin
         state_reg   <= IDLE;
         acc_reg     <= '0;
         result_reg  <= '0;
         tap_cnt_reg <= '0;
         bit_cnt_reg <= '0;
         mcand_reg   <= '0;
         prod_reg    <= '0;
         mplier_reg  <= '0;
         sign_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  acc_reg     <= '0;
                  tap_cnt_reg <= '0;
               end
            end
            WAIT_TAP: begin
               if (bus.in_valid) begin
                  mcand_reg   <= {{DATA_W{1'b0}}, pixel_mag};
                  mplier_reg  <= weight_mag;
                  sign_reg    <= bus.pixel[DATA_W-1] ^ bus.weight[DATA_W-1];
                  prod_reg    <= '0;
                  bit_cnt_reg <= '0;
               end
            end
            MUL: begin
               if (mplier_reg[0]) prod_reg <= prod_reg + mcand_reg;
               mcand_reg   <= mcand_reg << 1;
               mplier_reg  <= mplier_reg >> 1;
               bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            end
            ACC: begin
               // result tracks the running sum so it only changes once a new window adds a tap
               acc_reg     <= acc_sum;
               result_reg  <= acc_sum;
               tap_cnt_reg <= tap_cnt_inc;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state_reg == WAIT_TAP);
   assign bus.out_valid = (state_reg == DONE);
   assign bus.busy      = (state_reg != IDLE);
   assign bus.result    = result_reg;
endmodule

// File: tb/tb_window_mac.sv
// Bench for window_mac: a TAPS=1 instance driven from a vector table and a
// TAPS=25 instance checked against a sum-of-products model with timing rules.
module tb_window_mac;
   localparam int DW = 16;
   localparam int AW = 40;

   logic CLK = 1'b0;
   logic R;
   always #5 CLK = ~CLK;

   window_mac_if #(.DATA_W(DW), .ACC_W(AW)) bus25 ();
   window_mac_if #(.DATA_W(DW), .ACC_W(AW)) bus1 ();

   window_mac #(.DATA_W(DW), .TAPS(25), .ACC_W(AW)) dut25 (.CLK(CLK), .R(R), .bus(bus25.slave));
   window_mac #(.DATA_W(DW), .TAPS(1),  .ACC_W(AW)) dut1  (.CLK(CLK), .R(R), .bus(bus1.slave));

   typedef struct {
      int     pixel;
      int     weight;
      longint expected;
   } vec_t;

   vec_t   vecs[12];
   int     px[25];
   int     wt[25];
   int     n_checks = 0;
   int     n_fail   = 0;
   longint prev_result = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic longint res25();
      return longint'($signed(bus25.result));
   endfunction

   // One full 25-tap window; valid_pct throttles in_valid, hold = cycles of out_ready=0 in DONE.
   task automatic do_window(input int valid_pct, input int hold);
      longint model = 0;
      int idx = 0, cyc = 0, first = -1, last_acc = -1, stalls = 0;
      bit waiting = 0;
      for (int k = 0; k < 25; k++) model += longint'(px[k]) * longint'(wt[k]);
      check("idle busy", bus25.busy, 0);
      bus25.out_ready = (hold == 0);
      bus25.start = 1'b1;
      @(negedge CLK);
      bus25.start = 1'b0;
      check("busy after start", bus25.busy, 1);
      check("result held until first acc", res25(), prev_result);
      while (idx < 25 && cyc < 5000) begin
         if (bus25.in_ready) begin
            if (waiting) begin
               check("tap latency", cyc - last_acc, 18);
               waiting = 0;
            end
            if ($urandom_range(0, 99) < valid_pct) begin
               bus25.in_valid = 1'b1;
               bus25.pixel    = 16'(px[idx]);
               bus25.weight   = 16'(wt[idx]);
               if (first < 0) first = cyc;
               last_acc = cyc;
               waiting  = 1;
               idx++;
            end else begin
               bus25.in_valid = 1'b0;
               bus25.pixel    = 16'($urandom);
               bus25.weight   = 16'($urandom);
               if (first >= 0) stalls++;
            end
         end else begin
            bus25.in_valid = 1'($urandom);
            bus25.pixel    = 16'($urandom);
            bus25.weight   = 16'($urandom);
         end
         @(negedge CLK);
         cyc++;
      end
      bus25.in_valid = 1'b0;
      check("taps accepted", idx, 25);
      while (!bus25.out_valid && cyc < 5000) begin
         check("in_ready low while finishing", bus25.in_ready, 0);
         @(negedge CLK);
         cyc++;
      end
      check("done reached", bus25.out_valid, 1);
      check("accept to done cycles", cyc - first, 450 + stalls);
      check("window result", res25(), model);
      for (int h = 0; h < hold; h++) begin
         check("bp out_valid", bus25.out_valid, 1);
         check("bp result", res25(), model);
         check("bp in_ready", bus25.in_ready, 0);
         bus25.start = 1'($urandom);
         @(negedge CLK);
      end
      bus25.out_ready = 1'b1;
      bus25.start = 1'b1;
      @(negedge CLK);
      bus25.start = 1'b0;
      check("out_valid after handshake", bus25.out_valid, 0);
      check("idle after handshake", bus25.busy, 0);
      @(negedge CLK);
      check("start in done not queued", bus25.busy, 0);
      check("result held in idle", res25(), model);
      prev_result = model;
      $display("window: valid_pct=%0d hold=%0d result=%0d expected=%0d stalls=%0d",
               valid_pct, hold, res25(), model, stalls);
   endtask

   initial begin
      int t, ov;
      bus25.start = 0; bus25.in_valid = 0; bus25.pixel = 0; bus25.weight = 0; bus25.out_ready = 1;
      bus1.start  = 0; bus1.in_valid  = 0; bus1.pixel  = 0; bus1.weight  = 0; bus1.out_ready  = 1;
      R = 1'b0;
      #1 R = 1'b1;
      #1;
      check("reset busy", bus25.busy, 0);
      check("reset in_ready", bus25.in_ready, 0);
      check("reset out_valid", bus25.out_valid, 0);
      check("reset result", res25(), 0);
      check("reset result taps1", longint'($signed(bus1.result)), 0);
      repeat (2) @(negedge CLK);
      R = 1'b0;
      @(negedge CLK);

      // Single-product windows on the TAPS=1 instance
      vecs[0] = '{-32768, -32768, 64'sd1073741824};
      vecs[1] = '{32767, -32768, -64'sd1073709056};
      vecs[2] = '{0, 5, 0};
      vecs[3] = '{-1, -1, 1};
      vecs[4] = '{32767, 32767, 64'sd1073676289};
      for (int i = 5; i < 12; i++) begin
         vecs[i].pixel    = int'($signed(16'($urandom)));
         vecs[i].weight   = int'($signed(16'($urandom)));
         vecs[i].expected = longint'(vecs[i].pixel) * longint'(vecs[i].weight);
      end
      for (int i = 0; i < 12; i++) begin
         bus1.start = 1'b1;
         @(negedge CLK);
         bus1.start = 1'b0;
         t = 0;
         while (!bus1.in_ready && t < 40) begin @(negedge CLK); t++; end
         check("taps1 in_ready", bus1.in_ready, 1);
         bus1.in_valid = 1'b1;
         bus1.pixel    = 16'(vecs[i].pixel);
         bus1.weight   = 16'(vecs[i].weight);
         @(negedge CLK);
         bus1.in_valid = 1'b0;
         t = 0;
         while (!bus1.out_valid && t < 40) begin @(negedge CLK); t++; end
         check("taps1 done", bus1.out_valid, 1);
         check("taps1 result", longint'($signed(bus1.result)), vecs[i].expected);
         $display("taps1: pixel=%0d weight=%0d result=%0d expected=%0d", vecs[i].pixel,
                  vecs[i].weight, longint'($signed(bus1.result)), vecs[i].expected);
         @(negedge CLK);
         check("taps1 out_valid drop", bus1.out_valid, 0);
      end

      // Constant pairs, no throttling
      for (int k = 0; k < 25; k++) begin px[k] = 3; wt[k] = -2; end
      do_window(100, 0);
      // Full-range random pairs with backpressure
      for (int k = 0; k < 25; k++) begin
         px[k] = int'($signed(16'($urandom)));
         wt[k] = int'($signed(16'($urandom)));
      end
      do_window(70, 10);
      // Ramp with randomly toggled in_valid
      for (int k = 0; k < 25; k++) begin px[k] = k + 1; wt[k] = 1; end
      do_window(50, 0);

      // Abort a window with a short reset while tap 12 is multiplying
      bus25.start = 1'b1;
      @(negedge CLK);
      bus25.start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         t = 0;
         while (!bus25.in_ready && t < 40) begin @(negedge CLK); t++; end
         check("abort in_ready", bus25.in_ready, 1);
         bus25.in_valid = 1'b1;
         bus25.pixel    = 16'(7);
         bus25.weight   = 16'(3);
         @(negedge CLK);
         bus25.in_valid = 1'b0;
      end
      repeat (3) @(negedge CLK);
      check("pre-abort busy", bus25.busy, 1);
      #2 R = 1'b1;
      #1;
      check("async reset busy", bus25.busy, 0);
      check("async reset in_ready", bus25.in_ready, 0);
      check("async reset out_valid", bus25.out_valid, 0);
      check("async reset result", res25(), 0);
      @(negedge CLK);
      R = 1'b0;
      ov = 0;
      for (int c = 0; c < 30; c++) begin
         bus25.in_valid = 1'($urandom);
         @(negedge CLK);
         if (bus25.out_valid || bus25.busy) ov++;
      end
      bus25.in_valid = 1'b0;
      check("no activity after abort", ov, 0);
      prev_result = 0;
      for (int k = 0; k < 25; k++) begin px[k] = 1; wt[k] = 1; end
      do_window(100, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/window_mac.md
WINDOW_MAC -- requirements
Module: window_mac

Interface
REQ-001 Parameter DATA_W, default 16: width of the signed two's-complement pixel and weight operands.
REQ-002 Parameter TAPS, default 25: products accumulated per window (5x5 kernel); legal range 1..255.
REQ-003 Parameter ACC_W, default 40: signed accumulator and result width; must be at least 2*DATA_W+8.
REQ-004 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-005 R  input  1  reset, asynchronous, active-high; the same convention as the team's dffr cell.
REQ-006 start  input  1  one-cycle request to begin a new window; honoured only in IDLE.
REQ-007 in_valid  input  1  pixel/weight pair valid.
REQ-008 in_ready  output  1  block will accept a pair this cycle.
REQ-009 pixel  input  DATA_W  signed activation.
REQ-010 weight  input  DATA_W  signed kernel coefficient.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 result  output  ACC_W  signed sum of TAPS products.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, WAIT_TAP, MUL, ACC, DONE.
REQ-016 IDLE: on start=1 -> clear accumulator and tap counter, go to WAIT_TAP next cycle; otherwise stay.
REQ-017 WAIT_TAP: in_ready=1; a pair transfers when in_valid&in_ready, capturing operand magnitudes, product sign (pixel sign XOR weight sign), and going to MUL.
REQ-018 in_ready SHALL be 0 in every state other than WAIT_TAP; in_valid in other states is ignored.
REQ-019 MUL: iterative shift-add on magnitudes, one multiplier bit per cycle, LSB first, exactly DATA_W cycles, then ACC.
REQ-020 Magnitude of -2^(DATA_W-1) SHALL be taken as 2^(DATA_W-1) unsigned; (-32768)*(-32768) = +1073741824 exactly.
REQ-021 ACC: one cycle; sign-extended signed product added to the accumulator; tap counter increments; if the new count equals TAPS -> DONE, else WAIT_TAP.
REQ-022 Per-tap latency from accept to next in_ready SHALL be DATA_W+2 cycles (18 at default).
REQ-023 Accumulator SHALL wrap modulo 2^ACC_W without saturation; with legal parameters no overflow occurs.
REQ-024 DONE: out_valid=1, result=accumulator, both held stable until out_valid&out_ready; that cycle -> IDLE, out_valid falls the next cycle.
REQ-025 start asserted outside IDLE SHALL be ignored and not queued.
REQ-026 start and out_ready in the same cycle in DONE: handshake completes, start ignored.
REQ-027 result SHALL hold its last value in IDLE until the next window's first ACC cycle.
REQ-028 TAPS=1 SHALL yield a single product in result after one MUL/ACC pass.

Reset
REQ-029 R=1 SHALL immediately force state IDLE, accumulator 0, tap counter 0, in_ready=0, out_valid=0, busy=0, result=0, regardless of the clock.
REQ-030 R asserted mid-window (any state) SHALL abandon the window; no out_valid is produced for it.
REQ-031 The first start after R deasserts SHALL begin a clean window.

Verification
REQ-032 Default parameters, start, 25 pairs pixel=3, weight=-2, out_ready=1 -> out_valid once, result=-150, 25*18 cycles from first accept to DONE.
REQ-033 Single pair per window (TAPS=1): pixel=-32768, weight=-32768 -> result=+1073741824; pixel=32767, weight=-32768 -> result=-1073709056.
REQ-034 Backpressure: out_ready held 0 for 10 cycles in DONE -> out_valid and result stable for all 10, in_ready=0, start pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-035 in_valid toggled randomly, pairs pixel=k, weight=1 for k=1..25 -> result=325; no pair accepted while in_ready=0.
REQ-036 R pulsed for 1 cycle during MUL of tap 12 -> all outputs 0 asynchronously; new window of 25 pairs (1,1) -> result=25.
REQ-037 Gate-level: netlist synthesized to the team cell library passes REQ-032..036 identically to RTL.
